pipeline_fsm: RTL and testbench
===============================

// Module: pipeline_fsm
//
// PURPOSE
// Token-shift sequencer that drives the write_en / sel controls of Register, Delay, Prev and Mux
// instances in a pipelined datapath. An accepted `go` launches a token that appears on state[i]
// exactly i cycles later. A minimum initiation interval (II) between launches is enforced.
// Sits directly upstream of the storage primitives; one instance per scheduled component.
//
// PARAMETERS
// STATES  default 4  number of state outputs (>=1); state[STATES-1] is the last scheduled cycle
// II      default 1  minimum cycles between accepted go pulses (1 <= II <= STATES)
//
// PORTS
// clk          input   1       clock; all state updates on posedge
// reset        input   1       synchronous, active-high reset
// go           input   1       launch request; sampled every cycle
// ready        output  1       1 = a go this cycle will be accepted
// state        output  STATES  state[i] = 1 exactly i cycles after an accepted go
// overlap_err  output  1       sticky flag: go asserted while ready=0
//
// BEHAVIOUR
// - accept = go & ready & !reset. state[0] = accept (combinational, zero latency).
// - state[i], i>=1: registered shift chain; state[i] <= state[i-1] each cycle. Tokens never merge or stall.
// - Throughput: up to ceil(STATES/II) tokens in flight. Each bit is independent.
// - II counter: cnt, width $clog2(II) (min 1 bit).
//   - On accept: cnt <= II-1.
//   - Otherwise, if cnt != 0: cnt <= cnt-1.
//   - ready = (cnt == 0) & !reset.
//   - II=1: ready is constant 1 outside reset, and go is accepted every cycle.
// - Rejected go (go & !ready & !reset):
//   - No token is launched. cnt is unaffected.
//   - overlap_err <= 1. It stays 1 until reset.
// - Reset (synchronous, any cycle, including mid-operation):
//   - During the reset cycle: ready=0 and state[0]=0. go is ignored and does not set overlap_err.
//   - After the edge: state[STATES-1:1]=0, cnt=0, overlap_err=0. All in-flight tokens are discarded.
//   - First cycle after reset deasserts: ready=1.
// - Simultaneous go on the same cycle cnt reaches 0: ready is already 1, so the go is accepted (back-to-back at exactly II).
// - STATES=1: no shift registers. state[0] is the only output; the II logic still applies.
// - No X on any output after the first reset. Outputs are undefined before the first reset.
//
// TESTING
// - Reset, then STATES=4, II=1:
//   - single go at cycle 0 -> state = 0001, 0010, 0100, 1000, then 0000; ready always 1.
//   - go held high 6 cycles -> state[3:1] = 111 in steady state; overlap_err stays 0.
// - II=3: go at cycles 0,1,2,3 -> accepted at 0 and 3 only.
//   - ready = 1,0,0,1.
//   - overlap_err = 1 from cycle 2 onward (set by the go at cycle 1).
//   - state[1] high at cycles 1 and 4.
// - Reset mid-flight: go at 0, reset at cycle 2 -> state all 0 from cycle 3; ready=0 at cycle 2, 1 at cycle 3.
// - go during reset -> no token, overlap_err stays 0.
// - STATES=1, II=2: go every cycle -> state[0] = 1,0,1,0,...; overlap_err=1 from cycle 2.

Source files
------------

// File: rtl/pipeline_fsm.sv
// Token-shift sequencer: an accepted go launches a one-hot token that walks up state[]
// one position per cycle, with a minimum initiation interval between launches.
module pipeline_fsm #(
    parameter int STATES = 4,
    parameter int II     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              ready,
    output logic [STATES-1:0] state,
    output logic              overlap_err
);

    localparam int            CW         = (II > 1) ? $clog2(II) : 1;
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(II - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err_q;
    logic          err_d;
    logic          ready_s;
    logic          accept_s;
    logic          reject_s;

    // Launch qualification; reset masks both acceptance and rejection.
    always_comb begin
        ready_s  = (cnt_q == CNT_ZERO) && !reset;
        accept_s = go && ready_s;
        reject_s = go && !ready_s && !reset;
    end

    // Initiation-interval countdown and sticky overlap flag next-state.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept_s) begin
            cnt_d = CNT_RELOAD;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (reject_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Counter and error flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    generate
        if (STATES > 1) begin : g_chain
            logic [STATES-1:1] chain_q;
            logic [STATES-1:1] chain_d;

            // Shift chain: tokens advance one stage per cycle and never merge or stall.
            always_comb begin
                chain_d    = chain_q;
                chain_d[1] = accept_s;
                for (int i = 2; i < STATES; i++) begin
                    chain_d[i] = chain_q[i-1];
                end
            end

            // Chain register; reset discards all in-flight tokens.
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign state = {chain_q, accept_s};
        end else begin : g_single
            assign state = accept_s;
        end
    endgenerate

    assign ready       = ready_s;
    assign overlap_err = err_q;

endmodule

// File: tb/tb_pipeline_fsm.sv
// Bench for pipeline_fsm: four configurations driven in parallel and checked against a
// timeline model (accept history, last reset, last accept) plus directed expectations.
module tb_pipeline_fsm;

    localparam int ND   = 4;
    localparam int MAXC = 2048;

    logic          clk = 1'b1;
    logic [ND-1:0] rst;
    logic [ND-1:0] go;
    logic [ND-1:0] rdy;
    logic [ND-1:0] err;
    logic [3:0]    s0;
    logic [3:0]    s1;
    logic [0:0]    s2;
    logic [5:0]    s3;
    logic [7:0]    st_obs [ND];

    int st_n [ND] = '{4, 4, 1, 6};
    int ii_n [ND] = '{1, 3, 2, 4};

    bit acc      [ND][MAXC];
    int last_rst [ND];
    int last_acc [ND];
    bit err_m    [ND];
    bit en       [ND];
    bit rdy_e    [ND];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign st_obs[0] = {4'b0000, s0};
    assign st_obs[1] = {4'b0000, s1};
    assign st_obs[2] = {7'b0000000, s2};
    assign st_obs[3] = {2'b00, s3};

    pipeline_fsm #(.STATES(4), .II(1)) u_d0 (
        .clk(clk), .reset(rst[0]), .go(go[0]), .ready(rdy[0]), .state(s0), .overlap_err(err[0])
    );
    pipeline_fsm #(.STATES(4), .II(3)) u_d1 (
        .clk(clk), .reset(rst[1]), .go(go[1]), .ready(rdy[1]), .state(s1), .overlap_err(err[1])
    );
    pipeline_fsm #(.STATES(1), .II(2)) u_d2 (
        .clk(clk), .reset(rst[2]), .go(go[2]), .ready(rdy[2]), .state(s2), .overlap_err(err[2])
    );
    pipeline_fsm #(.STATES(6), .II(4)) u_d3 (
        .clk(clk), .reset(rst[3]), .go(go[3]), .ready(rdy[3]), .state(s3), .overlap_err(err[3])
    );

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, d, cyc, obs, exp_v);
        end
    endtask

    // Expected d0 state after a single go at k=0 and go held for k=5..10.
    function automatic logic [7:0] d0_exp(input int k);
        case (k)
            0:       return 8'h01;
            1:       return 8'h02;
            2:       return 8'h04;
            3:       return 8'h08;
            4:       return 8'h00;
            5:       return 8'h01;
            6:       return 8'h03;
            7:       return 8'h07;
            default: return 8'h0f;
        endcase
    endfunction

    // Model: token at state[i] iff a go was accepted i cycles ago with no reset since.
    task automatic model_check();
        logic [7:0] exp_st;
        for (int d = 0; d < ND; d++) begin
            rdy_e[d] = !rst[d] && ((cyc - last_acc[d]) >= ii_n[d]);
            exp_st   = 8'h00;
            for (int i = 0; i < st_n[d]; i++) begin
                if (i == 0) begin
                    exp_st[0] = go[d] && rdy_e[d];
                end else if ((cyc - i) >= 0 && last_rst[d] < (cyc - i)) begin
                    exp_st[i] = acc[d][cyc-i];
                end
            end
            chk("ready", d, 8'(rdy[d]), 8'(rdy_e[d]));
            if (en[d]) begin
                chk("state", d, st_obs[d], exp_st);
                chk("overlap_err", d, 8'(err[d]), 8'(err_m[d]));
            end else begin
                chk("state0", d, 8'(st_obs[d][0]), 8'(exp_st[0]));
            end
        end
    endtask

    task automatic model_update();
        bit a;
        for (int d = 0; d < ND; d++) begin
            a            = go[d] && rdy_e[d];
            acc[d][cyc]  = a;
            if (rst[d]) begin
                last_rst[d] = cyc;
                last_acc[d] = -1000;
                err_m[d]    = 1'b0;
                en[d]       = 1'b1;
            end else begin
                if (go[d] && !rdy_e[d]) err_m[d] = 1'b1;
                if (a) last_acc[d] = cyc;
            end
        end
        cyc++;
    endtask

    task automatic step_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic step_adv();
        @(posedge clk);
        #1;
        model_update();
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            last_rst[d] = -1;
            last_acc[d] = -1000;
            err_m[d]    = 1'b0;
            en[d]       = 1'b0;
        end

        // Reset cycle with go asserted everywhere: no token, no error.
        rst = '1;
        go  = '1;
        step_check();
        step_adv();
        rst = '0;

        for (int k = 0; k < 16; k++) begin
            go[0]  = (k == 0) || (k >= 5 && k <= 10);
            go[1]  = (k <= 3) || (k == 8);
            rst[1] = (k == 10);
            go[2]  = 1'b1;
            go[3]  = 1'($urandom_range(0, 1));
            step_check();
            if (k == 0) begin
                for (int d = 0; d < ND; d++) chk("err_after_reset_go", d, 8'(err[d]), 8'h00);
            end
            if (k <= 10) chk("d0_seq", 0, 8'(s0), d0_exp(k));
            chk("d0_ready", 0, 8'(rdy[0]), 8'h01);
            chk("d0_err", 0, 8'(err[0]), 8'h00);
            if (k <= 3) begin
                chk("d1_ready", 1, 8'(rdy[1]), 8'((k == 0) || (k == 3)));
                chk("d1_err", 1, 8'(err[1]), 8'(k >= 2));
            end
            if (k >= 1 && k <= 4) chk("d1_state1", 1, 8'(s1[1]), 8'((k == 1) || (k == 4)));
            if (k == 10) chk("d1_ready_in_reset", 1, 8'(rdy[1]), 8'h00);
            if (k == 11) begin
                chk("d1_state_flushed", 1, 8'(s1), 8'h00);
                chk("d1_ready_post_reset", 1, 8'(rdy[1]), 8'h01);
                chk("d1_err_cleared", 1, 8'(err[1]), 8'h00);
            end
            if (k <= 5) chk("d2_state", 2, 8'(s2), 8'((k % 2) == 0));
            chk("d2_err", 2, 8'(err[2]), 8'(k >= 2));
            step_adv();
        end

        // Randomized phase with occasional resets on each instance.
        for (int n = 0; n < 500; n++) begin
            for (int d = 0; d < ND; d++) begin
                rst[d] = ($urandom_range(0, 24) == 0);
                go[d]  = ($urandom_range(0, 9) < 6);
            end
            step_check();
            step_adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
